execute: RTL and testbench

Execute stage of the smolproc pipeline, directly downstream of decode. Consumes the decoded opcode, destination register and two operand bytes, then performs ALU, shift, multiply, load/store, branch and halt operations. Produces a register-file writeback, memory read/write requests, a branch redirect to fetch, and a stall back to decode. Single-cycle ops retire in one cycle; shifts, multiply and loads are multi-cycle and hold decode via `stall_out`.

---
 rtl/execute.sv | 209 ++++++++++++++++++++
 tb/tb_execute.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute.sv
// Execute stage: ALU/branch/store retire in one cycle; shifts, multiply and loads iterate.
// Latency 0 for single-cycle ops, n for shift-by-n, 8 for MUL, 2 for LD; stall_out holds decode meanwhile.
module execute (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] opc_in,
  input  logic [1:0] dst_in,
  input  logic [7:0] data_a_in,
  input  logic [7:0] data_b_in,
  output logic       stall_out,
  output logic       wb_en,
  output logic [1:0] wb_addr,
  output logic [7:0] wb_data,
  output logic       mem_rd_en,
  output logic       mem_wr_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data,
  output logic       branch_wr_en,
  output logic [7:0] branch_wr,
  output logic       halted
);

  typedef enum logic [2:0] {IDLE, MULTI, LD1, LD2, HALT} state_t;
  typedef enum logic [1:0] {K_SHL, K_SHR, K_MUL} kind_t;

  state_t     state, state_d;
  kind_t      kind, kind_d;
  logic [7:0] acc, acc_d, mplier, mplier_d, prod, prod_d;
  logic [3:0] count, count_d;
  logic [1:0] dst_q, dst_d;
  logic       carry, carry_d, zero, zero_d;

  logic       wb_fire, mem_rd_en_d, mem_wr_en_d, branch_d;
  logic [7:0] wb_val, mem_addr_d, mem_wr_data_d, branch_wr_d;
  logic [1:0] wb_dst;

  logic [3:0] op;
  logic [2:0] shamt;
  logic [8:0] sum9, diff9;
  logic       accept;
  logic       unused_bits;

  assign op        = opc_in[7:4];
  assign shamt     = data_b_in[2:0];
  assign sum9      = {1'b0, data_a_in} + {1'b0, data_b_in};
  assign diff9     = {1'b0, data_a_in} - {1'b0, data_b_in};
  // The cycle carrying a taken-branch pulse squashes the wrong-path instruction.
  assign accept    = (state == IDLE) && in_valid && !branch_wr_en;
  assign stall_out = (state != IDLE);
  assign halted    = (state == HALT);
  assign unused_bits = ^{opc_in[3:0], zero};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            4'h6, 4'h7: if (shamt != 3'd0) state_d = MULTI;
            4'h8:       state_d = MULTI;
            4'hA:       state_d = LD1;
            4'hF:       state_d = HALT;
            default:    ;
          endcase
        end
      end
      MULTI:   if (count == 4'd1) state_d = IDLE;
      LD1:     state_d = LD2;
      LD2:     state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_fire       = 1'b0;
    wb_val        = wb_data;
    wb_dst        = dst_q;
    mem_rd_en_d   = 1'b0;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr;
    mem_wr_data_d = mem_wr_data;
    branch_d      = 1'b0;
    branch_wr_d   = branch_wr;
    carry_d       = carry;
    acc_d         = acc;
    mplier_d      = mplier;
    prod_d        = prod;
    count_d       = count;
    kind_d        = kind;
    dst_d         = dst_q;
    case (state)
      IDLE: begin
        if (accept) begin
          dst_d  = dst_in;
          wb_dst = dst_in;
          case (op)
            4'h1: begin wb_fire = 1'b1; wb_val = sum9[7:0];  carry_d = sum9[8];  end
            4'h2: begin wb_fire = 1'b1; wb_val = diff9[7:0]; carry_d = diff9[8]; end
            4'h3: begin wb_fire = 1'b1; wb_val = data_a_in & data_b_in; end
            4'h4: begin wb_fire = 1'b1; wb_val = data_a_in | data_b_in; end
            4'h5: begin wb_fire = 1'b1; wb_val = data_a_in ^ data_b_in; end
            4'h6, 4'h7: begin
              if (shamt == 3'd0) begin
                wb_fire = 1'b1;
                wb_val  = data_a_in;
              end else begin
                acc_d   = data_a_in;
                count_d = {1'b0, shamt};
                kind_d  = (op == 4'h6) ? K_SHL : K_SHR;
              end
            end
            4'h8: begin
              acc_d    = data_a_in;
              mplier_d = data_b_in;
              prod_d   = 8'd0;
              count_d  = 4'd8;
              kind_d   = K_MUL;
            end
            4'h9: begin wb_fire = 1'b1; wb_val = data_b_in; end
            4'hA: begin mem_rd_en_d = 1'b1; mem_addr_d = data_a_in; end
            4'hB: begin
              mem_wr_en_d   = 1'b1;
              mem_addr_d    = data_a_in;
              mem_wr_data_d = data_b_in;
            end
            4'hC: begin branch_d = 1'b1; branch_wr_d = data_a_in; end
            4'hD: if (data_b_in == 8'd0) begin branch_d = 1'b1; branch_wr_d = data_a_in; end
            4'hE: if (carry) begin branch_d = 1'b1; branch_wr_d = data_a_in; end
            default: ;
          endcase
        end
      end
      MULTI: begin
        // MUL: acc is the left-shifting multiplicand, mplier is consumed LSB first.
        case (kind)
          K_SHL:   acc_d = acc << 1;
          K_SHR:   acc_d = acc >> 1;
          default: begin
            if (mplier[0]) prod_d = prod + acc;
            acc_d    = acc << 1;
            mplier_d = mplier >> 1;
          end
        endcase
        count_d = count - 4'd1;
        if (count == 4'd1) begin
          wb_fire = 1'b1;
          wb_val  = (kind == K_MUL) ? prod_d : acc_d;
        end
      end
      LD2: begin
        wb_fire = 1'b1;
        wb_val  = mem_rd_data;
      end
      default: ;
    endcase
    zero_d = wb_fire ? (wb_val == 8'd0) : zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en        <= 1'b0;
      wb_addr      <= 2'd0;
      wb_data      <= 8'd0;
      mem_rd_en    <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_addr     <= 8'd0;
      mem_wr_data  <= 8'd0;
      branch_wr_en <= 1'b0;
      branch_wr    <= 8'd0;
      carry        <= 1'b0;
      zero         <= 1'b0;
      acc          <= 8'd0;
      mplier       <= 8'd0;
      prod         <= 8'd0;
      count        <= 4'd0;
      kind         <= K_SHL;
      dst_q        <= 2'd0;
    end else begin
      wb_en        <= wb_fire;
      if (wb_fire) begin
        wb_addr <= wb_dst;
        wb_data <= wb_val;
      end
      mem_rd_en    <= mem_rd_en_d;
      mem_wr_en    <= mem_wr_en_d;
      mem_addr     <= mem_addr_d;
      mem_wr_data  <= mem_wr_data_d;
      branch_wr_en <= branch_d;
      branch_wr    <= branch_wr_d;
      carry        <= carry_d;
      zero         <= zero_d;
      acc          <= acc_d;
      mplier       <= mplier_d;
      prod         <= prod_d;
      count        <= count_d;
      kind         <= kind_d;
      dst_q        <= dst_d;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Randomized bench for execute: a reference model predicts each output event and its edge; a monitor pops and compares.
module tb_execute;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] opc_in = 8'd0;
  logic [1:0] dst_in = 2'd0;
  logic [7:0] data_a_in = 8'd0;
  logic [7:0] data_b_in = 8'd0;
  logic       stall_out, wb_en, mem_rd_en, mem_wr_en, branch_wr_en, halted;
  logic [1:0] wb_addr;
  logic [7:0] wb_data, mem_addr, mem_wr_data, branch_wr;
  logic [7:0] mem_rd_data = 8'd0;

  always #5 clk = ~clk;

  execute dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opc_in(opc_in), .dst_in(dst_in),
    .data_a_in(data_a_in), .data_b_in(data_b_in), .stall_out(stall_out),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .branch_wr_en(branch_wr_en), .branch_wr(branch_wr), .halted(halted)
  );

  typedef struct {
    int         edge_n;
    logic [1:0] dst;
    logic [7:0] addr;
    logic [7:0] dat;
  } ev_t;

  ev_t wbq[$], rdq[$], wrq[$], brq[$];
  int  checks = 0, errors = 0, ecnt = 0;
  int  free_at = 0, stall_lo = 1, stall_hi = 0, halt_edge = 1 << 30;
  bit  carry_m = 1'b0;
  logic [7:0] tbmem[256];
  logic [7:0] sh_mem[256];

  always @(posedge clk) ecnt <= ecnt + 1;

  // Data memory with one-cycle synchronous read.
  always @(posedge clk) begin
    if (mem_wr_en) tbmem[mem_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= tbmem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      check("stall_out", stall_out, (ecnt >= halt_edge) || (ecnt >= stall_lo && ecnt <= stall_hi));
      check("halted", halted, ecnt >= halt_edge);
      if (wb_en) begin
        if (wbq.size() == 0) check("wb_unexpected", 1, 0);
        else begin
          e = wbq.pop_front();
          check("wb_edge", ecnt, e.edge_n);
          check("wb_addr", wb_addr, e.dst);
          check("wb_data", wb_data, e.dat);
        end
      end
      if (mem_wr_en) begin
        if (wrq.size() == 0) check("memwr_unexpected", 1, 0);
        else begin
          e = wrq.pop_front();
          check("memwr_edge", ecnt, e.edge_n);
          check("memwr_addr", mem_addr, e.addr);
          check("memwr_data", mem_wr_data, e.dat);
        end
      end
      if (mem_rd_en) begin
        if (rdq.size() == 0) check("memrd_unexpected", 1, 0);
        else begin
          e = rdq.pop_front();
          check("memrd_edge", ecnt, e.edge_n);
          check("memrd_addr", mem_addr, e.addr);
        end
      end
      if (branch_wr_en) begin
        if (brq.size() == 0) check("branch_unexpected", 1, 0);
        else begin
          e = brq.pop_front();
          check("branch_edge", ecnt, e.edge_n);
          check("branch_target", branch_wr, e.addr);
        end
      end
    end
  end

  task automatic push_wb(input int e, input logic [1:0] d, input int r);
    wbq.push_back('{edge_n: e, dst: d, addr: 8'h00, dat: 8'(r)});
  endtask

  task automatic push_br(input int e, input logic [7:0] t);
    brq.push_back('{edge_n: e, dst: 2'd0, addr: t, dat: 8'h00});
    free_at = e + 2;
  endtask

  // Instruction accepted at edge e: predict every output event and when the stage frees up.
  task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] d, input int e);
    int ai, bi, s, r;
    ai = a; bi = b; s = bi % 8;
    free_at = e + 1;
    case (op)
      4'd1: begin r = ai + bi; carry_m = (r > 255); push_wb(e, d, r); end
      4'd2: begin carry_m = (ai < bi); push_wb(e, d, ai - bi); end
      4'd3: push_wb(e, d, ai & bi);
      4'd4: push_wb(e, d, ai | bi);
      4'd5: push_wb(e, d, ai ^ bi);
      4'd6, 4'd7: begin
        r = (op == 4'd6) ? (ai << s) : (ai >> s);
        push_wb(e + s, d, r);
        if (s > 0) begin stall_lo = e; stall_hi = e + s - 1; free_at = e + s + 1; end
      end
      4'd8: begin push_wb(e + 8, d, ai * bi); stall_lo = e; stall_hi = e + 7; free_at = e + 9; end
      4'd9: push_wb(e, d, bi);
      4'd10: begin
        rdq.push_back('{edge_n: e, dst: 2'd0, addr: a, dat: 8'h00});
        push_wb(e + 2, d, sh_mem[a]);
        stall_lo = e; stall_hi = e + 1; free_at = e + 3;
      end
      4'd11: begin
        wrq.push_back('{edge_n: e, dst: 2'd0, addr: a, dat: b});
        sh_mem[a] = b;
      end
      4'd12: push_br(e, a);
      4'd13: if (bi == 0) push_br(e, a);
      4'd14: if (carry_m) push_br(e, a);
      4'd15: begin halt_edge = e; free_at = 1 << 30; end
      default: ;
    endcase
  endtask

  // Present an instruction; hold it until accepted, or drop it after one cycle when hold is 0.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] d, input bit hold);
    bit done, acc;
    int e, guard;
    done = 1'b0; guard = 0;
    in_valid = 1'b1; opc_in = {op, 4'($urandom_range(15))};
    data_a_in = a; data_b_in = b; dst_in = d;
    while (!done) begin
      e = ecnt + 1;
      acc = (e >= free_at);
      @(posedge clk); #1;
      if (acc) begin model(op, a, b, d, e); done = 1'b1; end
      else if (!hold) done = 1'b1;
      guard++;
      if (!done && guard > 40) begin check("accept_timeout", 0, 1); done = 1'b1; end
    end
    in_valid = 1'b0;
    data_a_in = 8'($urandom); data_b_in = 8'($urandom);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs();
    check("rst_stall_out", stall_out, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_wr_en", mem_wr_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wr_data", mem_wr_data, 0);
    check("rst_branch_wr_en", branch_wr_en, 0);
    check("rst_branch_wr", branch_wr, 0);
    check("rst_halted", halted, 0);
  endtask

  // Asynchronous reset asserted mid-cycle for one clock edge; in-flight work is forgotten.
  task automatic do_reset();
    rst_n = 1'b0;
    wbq.delete(); rdq.delete(); wrq.delete(); brq.delete();
    free_at = 0; stall_lo = 1; stall_hi = 0; halt_edge = 1 << 30; carry_m = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic random_run(input int n);
    logic [3:0] op;
    logic [7:0] a, b;
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(14));
      a = (op == 4'd10 || op == 4'd11) ? 8'($urandom_range(15)) : 8'($urandom);
      b = (op == 4'd13 && $urandom_range(1) == 0) ? 8'd0 : 8'($urandom);
      issue(op, a, b, 2'($urandom_range(3)), $urandom_range(7) != 0);
      if ($urandom_range(3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbmem[i]  = 8'(i * 7 + 3);
      sh_mem[i] = 8'(i * 7 + 3);
    end
    #2;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(4'h1, 8'hF0, 8'h20, 2'd2, 1'b1);
    issue(4'hE, 8'h40, 8'($urandom), 2'd0, 1'b1);
    idle(2);
    issue(4'h6, 8'h03, 8'h05, 2'd1, 1'b1);
    issue(4'h6, 8'h03, 8'h00, 2'd3, 1'b1);
    idle(1);
    issue(4'h8, 8'h0D, 8'h0B, 2'd0, 1'b1);
    issue(4'h1, 8'h11, 8'h22, 2'd1, 1'b1);
    issue(4'hB, 8'h10, 8'h55, 2'd0, 1'b1);
    issue(4'hA, 8'h10, 8'h00, 2'd1, 1'b1);
    issue(4'hC, 8'h80, 8'h00, 2'd0, 1'b1);
    issue(4'h1, 8'h01, 8'h01, 2'd3, 1'b0);
    idle(3);

    random_run(300);
    idle(12);

    issue(4'hF, 8'h00, 8'h00, 2'd0, 1'b1);
    idle(5);
    do_reset();
    idle(2);
    issue(4'h8, 8'h37, 8'h5A, 2'd2, 1'b1);
    idle(3);
    do_reset();
    idle(12);

    random_run(60);
    idle(12);
    check("wb_drained", wbq.size(), 0);
    check("memrd_drained", rdq.size(), 0);
    check("memwr_drained", wrq.size(), 0);
    check("branch_drained", brq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
